// File: rtl/stopwatch_bcd_if.sv
// Stopwatch I/O bundle.
// master : the side that drives slow_clk and the buttons, and observes the display.
// slave  : the stopwatch itself.
// Signals:
//   slow_clk        divider square wave (counted on its rising edge)
//   btn_start_stop  start/stop button level (acts on rising edge)
//   btn_clear       clear button level
//   btn_lap         lap button level (acts on rising edge when lap hold is built)
//   bcd             displayed BCD count, digit 0 in bits [3:0]
//   running         high while counting is enabled
//   wrap            one-cycle pulse on roll-over to all zeros
//   held            high while the display is frozen on a lap snapshot
interface stopwatch_bcd_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    slow_clk;
  logic                    btn_start_stop;
  logic                    btn_clear;
  logic                    btn_lap;
  logic [4*NUM_DIGITS-1:0] bcd;
  logic                    running;
  logic                    wrap;
  logic                    held;

  modport master (
    output slow_clk, btn_start_stop, btn_clear, btn_lap,
    input  bcd, running, wrap, held
  );

  modport slave (
    input  slow_clk, btn_start_stop, btn_clear, btn_lap,
    output bcd, running, wrap, held
  );
endinterface

// File: rtl/stopwatch_bcd.sv
// Decimal stopwatch. Counts rising edges of slow_clk (sampled in the clk_50mhz
// domain) in BCD while running; start/stop toggles counting, clear returns to
// idle with a zero count.
// Optional feature macro: LAP_HOLD_EN -- when defined, a lap press freezes the
// display on a snapshot while the internal count keeps advancing.
// Ports:
//   clk_50mhz  system clock
//   rst        synchronous active-high reset
//   sw         stopwatch_bcd_if.slave (inputs slow_clk/buttons, outputs bcd/
//              running/wrap/held)
module stopwatch_bcd #(
  parameter int NUM_DIGITS = 4
) (
  input logic             clk_50mhz,
  input logic             rst,
  stopwatch_bcd_if.slave  sw
);
  localparam int W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t         state_reg;
  logic [W-1:0]   count_reg;
  logic [W-1:0]   count_inc;
  logic           wrap_reg;
  logic           slow_q_reg;
  logic           btn_ss_q_reg;
  logic [NUM_DIGITS:0] carry;

  logic tick;
  logic start;

  assign tick  = sw.slow_clk & ~slow_q_reg;
  assign start = sw.btn_start_stop & ~btn_ss_q_reg;

  // Ripple the +1 through the digits: a digit advances only when every lower
  // digit is 9, so carry[NUM_DIGITS] doubles as the all-nines flag.
  assign carry[0] = 1'b1;
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] digit;
      assign digit = count_reg[4*gi +: 4];
      assign carry[gi+1] = carry[gi] & (digit == 4'd9);
      assign count_inc[4*gi +: 4] = !carry[gi]       ? digit :
                                    (digit == 4'd9)  ? 4'd0  :
                                                       digit + 4'd1;
    end
  endgenerate

`ifdef LAP_HOLD_EN
  logic         btn_lap_q_reg;
  logic         held_reg;
  logic [W-1:0] snapshot_reg;
  logic         lap;

  assign lap = sw.btn_lap & ~btn_lap_q_reg;

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      btn_lap_q_reg <= 1'b1;
      held_reg      <= 1'b0;
      snapshot_reg  <= '0;
    end else begin
      btn_lap_q_reg <= sw.btn_lap;
      if (sw.btn_clear) begin
        held_reg <= 1'b0;
      end else if (lap) begin
        if (held_reg) begin
          held_reg <= 1'b0;
        end else if (state_reg == RUN) begin
          // Snapshot the count as it stood before any tick in this cycle.
          snapshot_reg <= count_reg;
          held_reg     <= 1'b1;
        end
      end
    end
  end

  assign sw.held = held_reg;
  assign sw.bcd  = held_reg ? snapshot_reg : count_reg;
`else
  logic unused_lap;
  assign unused_lap = sw.btn_lap;
  assign sw.held    = 1'b0;
  assign sw.bcd     = count_reg;
`endif

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      // Edge registers start high so a level already present at reset
      // release is not mistaken for an edge.
      slow_q_reg   <= 1'b1;
      btn_ss_q_reg <= 1'b1;
      state_reg    <= IDLE;
      count_reg    <= '0;
      wrap_reg     <= 1'b0;
    end else begin
      slow_q_reg   <= sw.slow_clk;
      btn_ss_q_reg <= sw.btn_start_stop;
      wrap_reg     <= 1'b0;
      if (sw.btn_clear) begin
        state_reg <= IDLE;
        count_reg <= '0;
      end else begin
        unique case (state_reg)
          IDLE: begin
            if (start) state_reg <= RUN;
          end
          RUN: begin
            // A tick coinciding with the stop press is still counted.
            if (tick) begin
              count_reg <= count_inc;
              wrap_reg  <= carry[NUM_DIGITS];
            end
            if (start) state_reg <= PAUSE;
          end
          PAUSE: begin
            if (start) state_reg <= RUN;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign sw.running = (state_reg == RUN);
  assign sw.wrap    = wrap_reg;
endmodule
